button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 28 ++
 rtl/button_conditioner_if.sv | 21 ++
 rtl/debounce_channel.sv | 143 ++++++++++++++
 rtl/button_conditioner.sv | 62 ++++++
 4 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner: channel indices, channel
// count, the per-channel debounce FSM state type and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

    localparam int N_BUTTONS = 3;

    // Channel indices into BUTTONS / LEVELS / PULSES
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_CLEAR = 2;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } btn_state_e;

    // Bits needed for a counter that runs 0 .. max_count-1 (at least one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button-side signals of the conditioner.
//   buttons : raw asynchronous buttons ([0] up, [1] down, [2] clear)
//   levels  : debounced button levels
//   pulses  : one-cycle press pulses
// Modports:
//   master : the button source / consumer (drives buttons, reads results)
//   slave  : the conditioner side (reads buttons, drives results)
// -----------------------------------------------------------------------------
interface button_conditioner_if;
    import button_pkg::*;

    logic [N_BUTTONS-1:0] buttons;
    logic [N_BUTTONS-1:0] levels;
    logic [N_BUTTONS-1:0] pulses;

    modport master (output buttons, input levels, input pulses);
    modport slave  (input buttons, output levels, output pulses);

endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-flop synchronizer, 4-state debounce FSM and a shared
// stable/hold counter. Emits a one-cycle registered pulse when a press is
// accepted and, with BUTTON_AUTOREPEAT_EN defined, repeat pulses while held.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   button_raw : raw asynchronous button input
//   level      : debounced level (high in PRESSED / CONFIRM_RELEASE)
//   pulse      : one-cycle press pulse (unmasked)
// Configuration macro: BUTTON_AUTOREPEAT_EN (adds REPEAT_DELAY / REPEAT_PERIOD
// parameters and the repeat logic; absent by default).
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BUTTON_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY    = 50000000
   ,parameter int REPEAT_PERIOD   = 20000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic level,
    output logic pulse
);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > MAX_RPT) ? DEBOUNCE_CYCLES : MAX_RPT;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = cnt_width(CNT_MAX);

    // Terminal counts: the counter stops at these and never wraps.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic             sync1_q;
    logic             sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pulse_q, pulse_d;
`ifdef BUTTON_AUTOREPEAT_EN
    // Set after the first repeat pulse: later repeats use REPEAT_PERIOD.
    logic             repeating_q, repeating_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source (the synchronizer chain relies
    // on this to stay two stages deep).
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchronizer flops are reset too, so a button held
            // through reset is seen as a fresh rising edge and re-debounced.
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeating_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= button_raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
`ifdef BUTTON_AUTOREPEAT_EN
            repeating_q <= repeating_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred. The counter default
        // of zero also clears it on every state change.
        state_d     = state_q;
        cnt_d       = '0;
        pulse_d     = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        repeating_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = CONFIRM_PRESS;
                end
            end
            CONFIRM_PRESS: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = CONFIRM_RELEASE;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (cnt_q == (repeating_q ? PER_LAST : DLY_LAST)) begin
                    pulse_d     = 1'b1;
                    repeating_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    repeating_d = repeating_q;
                end
`endif
            end
            CONFIRM_RELEASE: begin
                // A bounce back to 1 returns to PRESSED; any repeat timing
                // restarts from the full delay.
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign level = (state_q == PRESSED) || (state_q == CONFIRM_RELEASE);
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Debounces three raw buttons (up, down, clear), reports debounced levels and
// one-cycle press pulses for a downstream up/down/clear counter. Clear has
// priority: a clear pulse masks up/down pulses in the same cycle, and
// simultaneous up and down pulses cancel each other. Levels are never masked.
// Ports:
//   CLOCK   : clock, rising edge
//   RESET   : synchronous active-high reset
//   BUTTONS : raw asynchronous buttons [0] up, [1] down, [2] clear
//   LEVELS  : debounced levels
//   PULSES  : masked one-cycle press pulses
// Configuration macro: BUTTON_AUTOREPEAT_EN enables auto-repeat pulses while a
// button is held (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [N_BUTTONS-1:0] BUTTONS,
    output logic [N_BUTTONS-1:0] LEVELS,
    output logic [N_BUTTONS-1:0] PULSES
);

    // Every timing parameter must allow at least one cycle.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: timing parameters must be >= 1");
    end

    logic [N_BUTTONS-1:0] chan_pulse;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
           ,.REPEAT_DELAY    (REPEAT_DELAY)
           ,.REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk        (CLOCK),
            .rst        (RESET),
            .button_raw (BUTTONS[i]),
            .level      (LEVELS[i]),
            .pulse      (chan_pulse[i])
        );
    end

    // Priority masking: clear wins over up/down; up+down together cancel.
    always_comb begin
        PULSES = chan_pulse;
        if (chan_pulse[BTN_CLEAR] || (chan_pulse[BTN_UP] && chan_pulse[BTN_DOWN])) begin
            PULSES[BTN_UP]   = 1'b0;
            PULSES[BTN_DOWN] = 1'b0;
        end
    end

endmodule
